// File: rtl/dcache_port_arbiter.sv
// Shares one dcache load/store port between NumPorts requesters: round-robin with
// request locking, two-phase load sequencing and load-ID remapping through a slot table.
module dcache_port_arbiter #(
    parameter int unsigned NumPorts       = 3,
    parameter int unsigned IndexWidth     = 12,
    parameter int unsigned TagWidth       = 44,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned IdWidth        = 2,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NumPorts-1:0]             req_data_req_i,
    input  logic [NumPorts-1:0]             req_we_i,
    input  logic [NumPorts*IndexWidth-1:0]  req_index_i,
    input  logic [NumPorts*TagWidth-1:0]    req_tag_i,
    input  logic [NumPorts-1:0]             req_tag_valid_i,
    input  logic [NumPorts-1:0]             req_kill_i,
    input  logic [NumPorts*DataWidth-1:0]   req_wdata_i,
    input  logic [NumPorts*DataWidth/8-1:0] req_be_i,
    input  logic [NumPorts*2-1:0]           req_size_i,
    input  logic [NumPorts*IdWidth-1:0]     req_id_i,
    output logic [NumPorts-1:0]             req_gnt_o,
    output logic [NumPorts-1:0]             req_rvalid_o,
    output logic [DataWidth-1:0]            req_rdata_o,
    output logic [IdWidth-1:0]              req_rid_o,
    output logic                            dc_data_req_o,
    output logic                            dc_data_we_o,
    output logic [IndexWidth-1:0]           dc_address_index_o,
    output logic [TagWidth-1:0]             dc_address_tag_o,
    output logic                            dc_tag_valid_o,
    output logic                            dc_kill_req_o,
    output logic [DataWidth-1:0]            dc_data_wdata_o,
    output logic [DataWidth/8-1:0]          dc_data_be_o,
    output logic [1:0]                      dc_data_size_o,
    output logic [IdWidth-1:0]              dc_data_id_o,
    input  logic                            dc_data_gnt_i,
    input  logic                            dc_data_rvalid_i,
    input  logic [DataWidth-1:0]            dc_data_rdata_i,
    input  logic [IdWidth-1:0]              dc_data_rid_i
);

    localparam int unsigned PortW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam int unsigned BeW   = DataWidth / 8;

    typedef enum logic {S_IDLE, S_TAG} state_e;

    state_e                    r_state;
    logic [MaxOutstanding-1:0] r_valid;
    logic [PortW-1:0]          r_port [MaxOutstanding];
    logic [IdWidth-1:0]        r_id   [MaxOutstanding];
    logic [PortW-1:0]          r_rr_ptr;
    logic [PortW-1:0]          r_lock_sel;
    logic                      r_lock;
    logic [PortW-1:0]          r_owner;
    logic [IdWidth-1:0]        r_tag_slot;

    logic                      w_free_any;
    logic [IdWidth-1:0]        w_free_idx;
    logic [NumPorts-1:0]       w_elig;
    logic                      w_any;
    logic [PortW-1:0]          w_sel;
    logic                      w_sel_we;
    logic                      w_grant;
    logic                      w_tag_kill;
    logic                      w_rsp_hit;

    // Lowest free slot, from registered valid bits only
    always_comb begin
        w_free_any = 1'b0;
        w_free_idx = '0;
        for (int s = int'(MaxOutstanding) - 1; s >= 0; s--) begin
            if (!r_valid[s]) begin
                w_free_any = 1'b1;
                w_free_idx = IdWidth'(s);
            end
        end
    end

    assign w_elig = req_data_req_i & (req_we_i | {NumPorts{w_free_any}});

    // Held selection wins while its owner still requests; otherwise round-robin from rr_ptr+1
    always_comb begin
        int unsigned idx;
        idx   = 0;
        w_any = 1'b0;
        w_sel = r_rr_ptr;
        if (r_lock && w_elig[r_lock_sel]) begin
            w_any = 1'b1;
            w_sel = r_lock_sel;
        end else begin
            for (int unsigned k = 1; k <= NumPorts; k++) begin
                idx = 32'(r_rr_ptr) + k;
                if (idx >= NumPorts) idx = idx - NumPorts;
                if (!w_any && w_elig[idx]) begin
                    w_any = 1'b1;
                    w_sel = PortW'(idx);
                end
            end
        end
    end

    assign w_sel_we   = req_we_i[w_sel];
    assign w_grant    = (r_state == S_IDLE) && w_any && dc_data_gnt_i;
    assign w_tag_kill = (r_state == S_TAG) && (req_kill_i[r_owner] || !req_tag_valid_i[r_owner]);
    assign w_rsp_hit  = dc_data_rvalid_i && (32'(dc_data_rid_i) < MaxOutstanding)
                        && r_valid[dc_data_rid_i];

    // Cache-side muxes and requester-side grant / response routing
    always_comb begin
        req_gnt_o          = '0;
        req_rvalid_o       = '0;
        req_rdata_o        = '0;
        req_rid_o          = '0;
        dc_data_req_o      = 1'b0;
        dc_data_we_o       = 1'b0;
        dc_address_index_o = '0;
        dc_address_tag_o   = '0;
        dc_tag_valid_o     = 1'b0;
        dc_kill_req_o      = 1'b0;
        dc_data_wdata_o    = '0;
        dc_data_be_o       = '0;
        dc_data_size_o     = '0;
        dc_data_id_o       = '0;
        if (r_state == S_IDLE) begin
            if (w_any) begin
                dc_data_req_o      = 1'b1;
                dc_data_we_o       = w_sel_we;
                dc_address_index_o = req_index_i[w_sel*IndexWidth +: IndexWidth];
                dc_data_wdata_o    = req_wdata_i[w_sel*DataWidth +: DataWidth];
                dc_data_be_o       = req_be_i[w_sel*BeW +: BeW];
                dc_data_size_o     = req_size_i[w_sel*2 +: 2];
                if (w_sel_we) begin
                    dc_address_tag_o = req_tag_i[w_sel*TagWidth +: TagWidth];
                    dc_data_id_o     = req_id_i[w_sel*IdWidth +: IdWidth];
                end else begin
                    dc_data_id_o     = w_free_idx;
                end
                req_gnt_o[w_sel] = dc_data_gnt_i;
            end
        end else begin
            dc_address_tag_o = req_tag_i[r_owner*TagWidth +: TagWidth];
            dc_tag_valid_o   = req_tag_valid_i[r_owner];
            dc_kill_req_o    = w_tag_kill;
            dc_data_id_o     = r_tag_slot;
        end
        if (w_rsp_hit) begin
            req_rvalid_o[r_port[dc_data_rid_i]] = 1'b1;
            req_rid_o                           = r_id[dc_data_rid_i];
            req_rdata_o                         = dc_data_rdata_i;
        end
    end

    // FSM, arbitration state and outstanding-load table
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_valid    <= '0;
            r_rr_ptr   <= PortW'(NumPorts - 1);
            r_lock     <= 1'b0;
            r_lock_sel <= '0;
            r_owner    <= '0;
            r_tag_slot <= '0;
            for (int s = 0; s < int'(MaxOutstanding); s++) begin
                r_port[s] <= '0;
                r_id[s]   <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_rr_ptr <= w_sel;
                        r_lock   <= 1'b0;
                        if (!w_sel_we) begin
                            r_valid[w_free_idx] <= 1'b1;
                            r_port[w_free_idx]  <= w_sel;
                            r_id[w_free_idx]    <= req_id_i[w_sel*IdWidth +: IdWidth];
                            r_owner             <= w_sel;
                            r_tag_slot          <= w_free_idx;
                            r_state             <= S_TAG;
                        end
                    end else if (w_any) begin
                        r_lock     <= 1'b1;
                        r_lock_sel <= w_sel;
                    end else begin
                        r_lock <= 1'b0;
                    end
                end
                S_TAG: begin
                    r_state <= S_IDLE;
                    if (w_tag_kill) r_valid[r_tag_slot] <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
            if (w_rsp_hit) r_valid[dc_data_rid_i] <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed bench for dcache_port_arbiter: each task drives one scenario and checks
// hand-computed expectations; inputs change 1 ns after posedge, outputs sampled 2 ns later.
module tb_dcache_port_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   req, we, tag_valid, kill;
    logic [35:0]  index;
    logic [131:0] tag;
    logic [95:0]  wdata;
    logic [11:0]  be;
    logic [5:0]   size;
    logic [5:0]   id;
    logic [2:0]   gnt_o, rvalid_o;
    logic [31:0]  rdata_o;
    logic [1:0]   rid_o;
    logic         dc_req, dc_we, dc_tag_valid, dc_kill;
    logic [11:0]  dc_index;
    logic [43:0]  dc_tag;
    logic [31:0]  dc_wdata;
    logic [3:0]   dc_be;
    logic [1:0]   dc_size, dc_id;
    logic         dc_gnt, dc_rvalid;
    logic [31:0]  dc_rdata;
    logic [1:0]   dc_rid;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dcache_port_arbiter dut (
        .clk_i(clk), .rst_i(rst),
        .req_data_req_i(req), .req_we_i(we), .req_index_i(index), .req_tag_i(tag),
        .req_tag_valid_i(tag_valid), .req_kill_i(kill), .req_wdata_i(wdata),
        .req_be_i(be), .req_size_i(size), .req_id_i(id),
        .req_gnt_o(gnt_o), .req_rvalid_o(rvalid_o), .req_rdata_o(rdata_o), .req_rid_o(rid_o),
        .dc_data_req_o(dc_req), .dc_data_we_o(dc_we), .dc_address_index_o(dc_index),
        .dc_address_tag_o(dc_tag), .dc_tag_valid_o(dc_tag_valid), .dc_kill_req_o(dc_kill),
        .dc_data_wdata_o(dc_wdata), .dc_data_be_o(dc_be), .dc_data_size_o(dc_size),
        .dc_data_id_o(dc_id), .dc_data_gnt_i(dc_gnt), .dc_data_rvalid_i(dc_rvalid),
        .dc_data_rdata_i(dc_rdata), .dc_data_rid_i(dc_rid)
    );

    task automatic clear_inputs();
        req = '0; we = '0; tag_valid = '0; kill = '0; index = '0; tag = '0;
        wdata = '0; be = '0; size = '0; id = '0;
        dc_gnt = 1'b0; dc_rvalid = 1'b0; dc_rdata = '0; dc_rid = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_req(input int p, input logic w, input logic [11:0] ix,
                           input logic [43:0] tg, input logic [1:0] i);
        req[p]           = 1'b1;
        we[p]            = w;
        index[p*12 +: 12] = ix;
        tag[p*44 +: 44]  = tg;
        id[p*2 +: 2]     = i;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        #2;
        total++; if (gnt_o !== 3'b000) begin bad++; $display("FAIL rst_gnt got=%b exp=000", gnt_o); end
        total++; if (dc_req !== 1'b0) begin bad++; $display("FAIL rst_dc_req got=%b exp=0", dc_req); end
        tick();
        rst = 1'b0;
        tick();
        #2;
        total++; if ({dc_req, dc_kill, dc_tag_valid, rvalid_o} !== 6'b0) begin
            bad++; $display("FAIL post_rst_outs got=%b exp=000000", {dc_req, dc_kill, dc_tag_valid, rvalid_o});
        end
        total++; if (dc_id !== 2'd0) begin bad++; $display("FAIL post_rst_id got=%0d exp=0", dc_id); end
    endtask

    task automatic test_load_basic();
        do_reset();
        set_req(1, 1'b0, 12'h0A4, 44'h0, 2'd2);
        dc_gnt = 1'b1;
        #2;
        total++; if (gnt_o !== 3'b010) begin bad++; $display("FAIL ld_gnt got=%b exp=010", gnt_o); end
        total++; if (dc_id !== 2'd0) begin bad++; $display("FAIL ld_slot got=%0d exp=0", dc_id); end
        total++; if ({dc_req, dc_we, dc_index} !== {1'b1, 1'b0, 12'h0A4}) begin
            bad++; $display("FAIL ld_mux got=%h exp=%h", {dc_req, dc_we, dc_index}, {1'b1, 1'b0, 12'h0A4});
        end
        tick();
        req = '0; dc_gnt = 1'b0;
        tag[44 +: 44] = 44'h123; tag_valid[1] = 1'b1;
        #2;
        total++; if ({dc_req, dc_tag_valid, dc_kill} !== 3'b010) begin
            bad++; $display("FAIL ld_tag_ctl got=%b exp=010", {dc_req, dc_tag_valid, dc_kill});
        end
        total++; if (dc_tag !== 44'h123) begin bad++; $display("FAIL ld_tag got=%h exp=123", dc_tag); end
        tick();
        tag_valid = '0;
        dc_rvalid = 1'b1; dc_rid = 2'd0; dc_rdata = 32'hDEADBEEF;
        #2;
        total++; if (rvalid_o !== 3'b010) begin bad++; $display("FAIL ld_rvalid got=%b exp=010", rvalid_o); end
        total++; if (rid_o !== 2'd2) begin bad++; $display("FAIL ld_rid got=%0d exp=2", rid_o); end
        total++; if (rdata_o !== 32'hDEADBEEF) begin bad++; $display("FAIL ld_rdata got=%h exp=deadbeef", rdata_o); end
        tick();
        dc_rvalid = 1'b0;
        #2;
        total++; if (rvalid_o !== 3'b000) begin bad++; $display("FAIL ld_rvalid_end got=%b exp=000", rvalid_o); end
        tick();
    endtask

    task automatic test_store_rr();
        logic [2:0] exp_gnt [4];
        exp_gnt = '{3'b001, 3'b010, 3'b100, 3'b001};
        do_reset();
        set_req(0, 1'b1, 12'h100, 44'h111, 2'd1);
        set_req(1, 1'b1, 12'h200, 44'h222, 2'd2);
        set_req(2, 1'b1, 12'h300, 44'h333, 2'd3);
        dc_gnt = 1'b1;
        #2;
        total++; if ({dc_tag, dc_id} !== {44'h111, 2'd1}) begin
            bad++; $display("FAIL st_passthru got=%h exp=%h", {dc_tag, dc_id}, {44'h111, 2'd1});
        end
        for (int k = 0; k < 4; k++) begin
            if (k != 0) #2;
            total++; if (gnt_o !== exp_gnt[k]) begin
                bad++; $display("FAIL st_rr_%0d got=%b exp=%b", k, gnt_o, exp_gnt[k]);
            end
            total++; if ({dc_req, dc_we} !== 2'b11) begin
                bad++; $display("FAIL st_notag_%0d got=%b exp=11", k, {dc_req, dc_we});
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_lock();
        do_reset();
        set_req(2, 1'b1, 12'h2C2, 44'h222, 2'd3);
        for (int k = 0; k < 3; k++) begin
            #2;
            total++; if ({gnt_o, dc_req, dc_index} !== {3'b000, 1'b1, 12'h2C2}) begin
                bad++; $display("FAIL lock_wait_%0d got=%h exp=%h", k, {gnt_o, dc_req, dc_index}, {3'b000, 1'b1, 12'h2C2});
            end
            tick();
        end
        set_req(0, 1'b1, 12'h0B0, 44'h0, 2'd0);
        #2;
        total++; if (dc_index !== 12'h2C2) begin bad++; $display("FAIL lock_hold got=%h exp=2c2", dc_index); end
        tick();
        dc_gnt = 1'b1;
        #2;
        total++; if (gnt_o !== 3'b100) begin bad++; $display("FAIL lock_gnt got=%b exp=100", gnt_o); end
        tick();
        req[2] = 1'b0;
        #2;
        total++; if ({gnt_o, dc_index} !== {3'b001, 12'h0B0}) begin
            bad++; $display("FAIL lock_next got=%h exp=%h", {gnt_o, dc_index}, {3'b001, 12'h0B0});
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_full_table();
        do_reset();
        for (int s = 0; s < 4; s++) begin
            set_req(0, 1'b0, 12'(16 * s), 44'h0, 2'(3 - s));
            dc_gnt = 1'b1;
            #2;
            total++; if (dc_id !== 2'(s)) begin bad++; $display("FAIL full_alloc_%0d got=%0d exp=%0d", s, dc_id, s); end
            tick();
            req[0] = 1'b0; dc_gnt = 1'b0; tag_valid[0] = 1'b1;
            tick();
            tag_valid[0] = 1'b0;
        end
        set_req(0, 1'b0, 12'h0F0, 44'h0, 2'd1);
        set_req(1, 1'b1, 12'h1F0, 44'h5, 2'd0);
        dc_gnt = 1'b1;
        #2;
        total++; if ({gnt_o, dc_we} !== {3'b010, 1'b1}) begin
            bad++; $display("FAIL full_store got=%b exp=0101", {gnt_o, dc_we});
        end
        tick();
        req[1] = 1'b0; dc_gnt = 1'b0;
        dc_rvalid = 1'b1; dc_rid = 2'd2; dc_rdata = 32'hCAFE0002;
        #2;
        total++; if ({rvalid_o, rid_o, dc_req} !== {3'b001, 2'd1, 1'b0}) begin
            bad++; $display("FAIL full_rsp got=%b exp=001010", {rvalid_o, rid_o, dc_req});
        end
        tick();
        dc_rvalid = 1'b0; dc_gnt = 1'b1;
        #2;
        total++; if ({gnt_o, dc_id} !== {3'b001, 2'd2}) begin
            bad++; $display("FAIL full_reuse got=%b exp=00110", {gnt_o, dc_id});
        end
        tick();
        req[0] = 1'b0; dc_gnt = 1'b0; tag_valid[0] = 1'b1;
        tick();
        clear_inputs();
    endtask

    task automatic test_kill();
        do_reset();
        set_req(0, 1'b0, 12'h010, 44'h0, 2'd1);
        dc_gnt = 1'b1;
        tick();
        req = '0; dc_gnt = 1'b0; tag_valid = '0; kill = '0;
        #2;
        total++; if ({dc_kill, dc_tag_valid} !== 2'b10) begin
            bad++; $display("FAIL kill_forced got=%b exp=10", {dc_kill, dc_tag_valid});
        end
        tick();
        set_req(1, 1'b0, 12'h020, 44'h0, 2'd3);
        #2;
        total++; if (dc_id !== 2'd0) begin bad++; $display("FAIL kill_freed got=%0d exp=0", dc_id); end
        tick();
        req = '0;
        dc_rvalid = 1'b1; dc_rid = 2'd0; dc_rdata = 32'h11112222;
        #2;
        total++; if (rvalid_o !== 3'b000) begin bad++; $display("FAIL kill_drop got=%b exp=000", rvalid_o); end
        tick();
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int s = 0; s < 2; s++) begin
            set_req(0, 1'b0, 12'h040, 44'h0, 2'(s));
            dc_gnt = 1'b1;
            tick();
            req = '0; dc_gnt = 1'b0; tag_valid[0] = 1'b1;
            tick();
            tag_valid = '0;
        end
        set_req(1, 1'b0, 12'h050, 44'h0, 2'd2);
        dc_gnt = 1'b1;
        tick();
        req = '0; dc_gnt = 1'b0; tag_valid[1] = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_inputs();
        #2;
        total++; if ({dc_req, dc_tag_valid, dc_kill} !== 3'b000) begin
            bad++; $display("FAIL mid_idle got=%b exp=000", {dc_req, dc_tag_valid, dc_kill});
        end
        dc_rvalid = 1'b1; dc_rid = 2'd1; dc_rdata = 32'h33334444;
        #1;
        total++; if (rvalid_o !== 3'b000) begin bad++; $display("FAIL mid_drop got=%b exp=000", rvalid_o); end
        tick();
        dc_rvalid = 1'b0;
        set_req(2, 1'b0, 12'h060, 44'h0, 2'd0);
        #2;
        total++; if (dc_id !== 2'd0) begin bad++; $display("FAIL mid_empty got=%0d exp=0", dc_id); end
        tick();
        req = '0;
        set_req(0, 1'b1, 12'h070, 44'h7, 2'd0);
        set_req(1, 1'b1, 12'h080, 44'h8, 2'd0);
        dc_gnt = 1'b1;
        #2;
        total++; if (gnt_o !== 3'b001) begin bad++; $display("FAIL mid_first got=%b exp=001", gnt_o); end
        tick();
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_load_basic();
        test_store_rr();
        test_lock();
        test_full_table();
        test_kill();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dcache_port_arbiter.md
Name: dcache_port_arbiter

Overview:
- Shares one dcache load/store request port between NumPorts requesters: the AXI dcache adapter, the PTW and the debug/DMA path.
- Round-robin arbitration with request locking, sequencing of the two-phase load protocol (index/grant, then tag one cycle later), and store pass-through.
- Load transaction IDs are remapped to an internal outstanding table so each read response is routed back to the requester that issued it.

Parameters:
- NumPorts, 3, number of requesters (≥2)
- IndexWidth, 12, DCACHE_INDEX_WIDTH
- TagWidth, 44, DCACHE_TAG_WIDTH
- DataWidth, 32, data bits per beat
- IdWidth, 2, TRANS_ID_BITS (requester-side and cache-side ID width)
- MaxOutstanding, 4, outstanding-load table depth (≤ 2**IdWidth)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_data_req_i  in  NumPorts  per-requester request valid
- req_we_i  in  NumPorts  1 = store
- req_index_i  in  NumPorts*IndexWidth  address index
- req_tag_i  in  NumPorts*TagWidth  address tag (stores: with request; loads: tag cycle)
- req_tag_valid_i  in  NumPorts  load tag valid
- req_kill_i  in  NumPorts  kill own load in its tag cycle
- req_wdata_i  in  NumPorts*DataWidth  store data
- req_be_i  in  NumPorts*DataWidth/8  byte enables
- req_size_i  in  NumPorts*2  access size
- req_id_i  in  NumPorts*IdWidth  requester transaction ID
- req_gnt_o  out  NumPorts  one-hot grant
- req_rvalid_o  out  NumPorts  one-hot read response valid
- req_rdata_o  out  DataWidth  read data (shared)
- req_rid_o  out  IdWidth  original requester ID of the response
- dc_data_req_o  out  1  cache request
- dc_data_we_o  out  1  store
- dc_address_index_o  out  IndexWidth  index
- dc_address_tag_o  out  TagWidth  tag
- dc_tag_valid_o  out  1  load tag valid
- dc_kill_req_o  out  1  kill load
- dc_data_wdata_o  out  DataWidth  store data
- dc_data_be_o  out  DataWidth/8  byte enables
- dc_data_size_o  out  2  size
- dc_data_id_o  out  IdWidth  table slot index
- dc_data_gnt_i  in  1  cache grant
- dc_data_rvalid_i  in  1  cache read valid
- dc_data_rdata_i  in  DataWidth  cache read data
- dc_data_rid_i  in  IdWidth  slot index of the response

Behaviour:
- Reset: FSM=IDLE, table valid bits=0, rr_ptr=NumPorts-1 so port 0 wins first, lock=0. All outputs are 0 while rst_i=1 and in the cycle after release, unless a requester drives a request.
- Eligibility: a requester is eligible when req_data_req_i[i]=1 and either (req_we_i[i]=1) or (a table slot is free per the registered valid bits). Stores are never blocked by a full table.
- Selection: round-robin starting at rr_ptr+1. If dc_data_req_o was 1 and not granted last cycle, the previous selection is locked and held until granted, even if a higher-priority requester appears. If the locked requester drops its request, the lock is released and selection is recomputed in the same cycle.
- IDLE:
  - dc_data_req_o = any eligible; muxes pass the selected requester's index, we, be, size and wdata.
  - For stores, dc_address_tag_o = req_tag_i[sel] and dc_data_id_o = req_id_i[sel].
  - For loads, dc_data_id_o = lowest free slot.
  - req_gnt_o[sel] = dc_data_gnt_i, combinational, 0-cycle latency.
- On grant:
  - rr_ptr←sel and lock←0.
  - Load: slot←{valid=1, port=sel, id=req_id_i[sel]}, owner←sel, FSM→TAG.
  - Store: stay in IDLE; no slot is allocated and no response is expected.
- TAG (exactly one cycle):
  - dc_data_req_o=0.
  - dc_address_tag_o = req_tag_i[owner], dc_tag_valid_o = req_tag_valid_i[owner], dc_kill_req_o = req_kill_i[owner].
  - If the owner asserts neither tag_valid nor kill, the arbiter forces dc_kill_req_o=1.
  - On kill, the slot is freed at the clock edge and no rvalid is expected.
  - FSM→IDLE.
- Response:
  - When dc_data_rvalid_i=1 and slot[dc_data_rid_i].valid: req_rvalid_o[slot.port]=1, req_rid_o=slot.id, req_rdata_o=dc_data_rdata_i (combinational), slot freed at the edge.
  - An rvalid to an invalid slot is dropped.
  - A slot freed in cycle N is allocatable from cycle N+1; same-cycle free and allocate of one slot is not allowed.
- Reset mid-transaction clears the table and FSM; in-flight cache responses after reset are dropped as invalid slots.

Test Plan:
- Port 1 load, index 0x0A4, tag 0x123, id 2, gnt same cycle -> req_gnt_o=3'b010, dc_data_id_o=0; next cycle dc_tag_valid_o=1 and tag=0x123; rvalid rid=0 data 0xDEADBEEF -> req_rvalid_o=3'b010, req_rid_o=2.
- Ports 0,1,2 issue continuous stores with gnt held 1 -> grants rotate 001,010,100,001, and no TAG cycles occur.
- Port 2 requests with gnt=0 for 3 cycles, then port 0 requests -> port 2 stays selected with stable muxes until gnt; port 0 is granted next.
- 4 loads outstanding with no rvalid, then port 0 issues a 5th load and port 1 a store -> load not eligible, store granted; the load is granted the cycle after the first rvalid, reusing the freed slot.
- Load granted, owner gives tag_valid=0 and kill=0 in TAG -> dc_kill_req_o=1, slot freed; a later rvalid on that slot produces no req_rvalid_o.
- rst_i pulsed during TAG with 2 loads outstanding -> FSM IDLE, table empty, subsequent rvalid rid=1 is dropped, and port 0 wins the first post-reset grant.
